// File: rtl/rr_decoder_arbiter_if.sv
// Requester-side bus of the round-robin decoder arbiter: request/done in, grant/select/enable out.
// fsm_state mirrors the arbiter FSM (0 idle, 1 grant, 2 release) for observation only.
interface rr_decoder_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic [1:0] fsm_state;

    // Handshake: a requester holds req[i] high until it sees gnt[i]. It keeps req[i] high
    // while it uses the resource, then pulses done for one cycle or drops req[i] to release.
    // gnt/gnt_idx/gnt_valid change only on clock edges. timeout marks the last cycle of a
    // grant that hit the hold limit.
    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout, fsm_state
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout, fsm_state
    );
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for one decoder-driven resource shared by 8 requesters.
// gnt_idx/gnt_valid feed the decoder select/enable. A grant ends on done, req drop or hold limit.
module rr_decoder_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input logic             clk,
    input logic             rst,
    rr_decoder_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  hold_cnt;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              held_req;
    logic              hold_hit;
    logic              release_now;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = ptr;
        cand     = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (bus.req[cand]) begin
                pick_any = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign held_req    = bus.req[gnt_idx];
    assign hold_hit    = (hold_cnt == HOLD_LAST);
    assign release_now = bus.done || !held_req || hold_hit;

    // done or a request drop in the same cycle makes the release voluntary.
    assign bus.timeout = !rst && (state == GRANT) && hold_hit && !bus.done && held_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                // The release cycle is the dead cycle itself, so it may arbitrate the next
                // grant: consecutive grants are separated by exactly one idle decoder cycle.
                IDLE, RELEASE: begin
                    if (pick_any) begin
                        state          <= GRANT;
                        gnt            <= '0;
                        gnt[pick_idx]  <= 1'b1;
                        gnt_idx        <= pick_idx;
                        gnt_valid      <= 1'b1;
                        hold_cnt       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt_valid = gnt_valid;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: reset, round robin, wrap, timeout, precedence, reset mid-grant.
// Grant invariants are checked on every falling edge once reset has been applied.
module tb_rr_decoder_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_decoder_arbiter_if bus();

    rr_decoder_arbiter #(
        .N_REQ   (8),
        .IDX_W   (3),
        .MAX_HOLD(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit inv_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            chk("inv_valid_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
            if (bus.gnt_valid)
                chk("inv_idx_enc", 32'(bus.gnt_idx), 32'(enc(bus.gnt)));
        end
    end

    initial begin
        logic [7:0] e_gnt;

        bus.req  = 8'hFF;
        bus.done = 1'b0;
        rst      = 1'b1;

        // reset held two cycles with all requests active
        cyc();
        cyc();
        chk("rst_gnt", 32'(bus.gnt), 32'h00);
        chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
        inv_en = 1'b1;
        rst    = 1'b0;
        cyc();
        chk("rst_first_gnt", 32'(bus.gnt), 32'h01);
        chk("rst_first_idx", 32'(bus.gnt_idx), 32'd0);

        // round robin 0..7,0 with done in each grant cycle
        for (int i = 0; i < 9; i++) begin
            e_gnt = 8'h01 << (i % 8);
            chk("rr_gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("rr_idx", 32'(bus.gnt_idx), 32'(i % 8));
            bus.done = 1'b1;
            if (i == 8) bus.req = 8'h00;
            cyc();
            bus.done = 1'b0;
            chk("rr_dead", 32'(bus.gnt_valid), 32'd0);
            cyc();
        end
        chk("idle_valid", 32'(bus.gnt_valid), 32'd0);
        chk("idle_idx_stable", 32'(bus.gnt_idx), 32'd0);

        // done while idle is ignored
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        chk("done_idle", 32'(bus.gnt_valid), 32'd0);

        // grant 5 so ptr becomes 6, then wrap to 0 and 1
        bus.req = 8'h20;
        cyc();
        chk("wrap_g5", 32'(bus.gnt), 32'h20);
        bus.done = 1'b1;
        bus.req  = 8'h03;
        cyc();
        bus.done = 1'b0;
        chk("wrap_dead", 32'(bus.gnt_valid), 32'd0);
        cyc();
        chk("wrap_g0", 32'(bus.gnt), 32'h01);
        chk("wrap_g0_idx", 32'(bus.gnt_idx), 32'd0);
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        cyc();
        chk("wrap_g1", 32'(bus.gnt), 32'h02);
        chk("wrap_g1_idx", 32'(bus.gnt_idx), 32'd1);

        // request drop releases without timeout
        bus.req = 8'h00;
        settle();
        chk("drop_no_to", 32'(bus.timeout), 32'd0);
        cyc();
        chk("drop_rel", 32'(bus.gnt), 32'h00);
        cyc();

        // hold limit: 15 grant cycles, timeout on the last one
        bus.req = 8'h10;
        cyc();
        for (int k = 1; k <= 15; k++) begin
            settle();
            chk("to_gnt", 32'(bus.gnt), 32'h10);
            chk("to_pulse", 32'(bus.timeout), (k == 15) ? 32'd1 : 32'd0);
            if (k < 15) cyc();
        end
        cyc();
        chk("to_rel", 32'(bus.gnt), 32'h00);
        chk("to_clear", 32'(bus.timeout), 32'd0);
        cyc();
        chk("to_regrant", 32'(bus.gnt), 32'h10);

        // done on the hold-limit cycle suppresses timeout
        for (int k = 1; k < 15; k++) cyc();
        bus.done = 1'b1;
        settle();
        chk("prec_done_to", 32'(bus.timeout), 32'd0);
        chk("prec_done_gnt", 32'(bus.gnt), 32'h10);
        cyc();
        bus.done = 1'b0;
        chk("prec_done_rel", 32'(bus.gnt_valid), 32'd0);
        chk("prec_done_to2", 32'(bus.timeout), 32'd0);
        cyc();
        chk("prec_regrant", 32'(bus.gnt), 32'h10);

        // request drop mid-grant
        cyc();
        cyc();
        bus.req = 8'h00;
        settle();
        chk("mid_drop_to", 32'(bus.timeout), 32'd0);
        cyc();
        chk("mid_drop_rel", 32'(bus.gnt_valid), 32'd0);
        chk("mid_drop_to2", 32'(bus.timeout), 32'd0);
        cyc();

        // reset during a grant clears the grant and the pointer
        bus.req = 8'h08;
        cyc();
        chk("rst_mid_pre", 32'(bus.gnt), 32'h08);
        bus.req = 8'hFF;
        rst     = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_mid_gnt", 32'(bus.gnt), 32'h00);
        chk("rst_mid_valid", 32'(bus.gnt_valid), 32'd0);
        cyc();
        chk("rst_mid_ptr_gnt", 32'(bus.gnt), 32'h01);
        chk("rst_mid_ptr_idx", 32'(bus.gnt_idx), 32'd0);

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
